// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: buffers µops until both operands are valid,
// snoops the ALU and LSB result buses, issues one ready µop per cycle. Optional: ALU_RS_BYPASS_EN.
module alu_rs #(
    parameter int RS_SIZE    = 16,
    parameter int ROB_ADDR_W = 4,
    parameter int OP_W       = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdy,
    input  logic                  has_misbranch,
    input  logic                  in_valid,
    input  logic [OP_W-1:0]       in_op,
    input  logic [31:0]           in_imm,
    input  logic [31:0]           in_pc,
    input  logic [4:0]            in_shamt,
    input  logic [ROB_ADDR_W-1:0] in_rd_robnum,
    input  logic                  in_rs1_ready,
    input  logic                  in_rs2_ready,
    input  logic [31:0]           in_rs1_val,
    input  logic [31:0]           in_rs2_val,
    input  logic [ROB_ADDR_W-1:0] in_rs1_tag,
    input  logic [ROB_ADDR_W-1:0] in_rs2_tag,
    input  logic                  alu_cdb_valid,
    input  logic [ROB_ADDR_W-1:0] alu_cdb_robnum,
    input  logic [31:0]           alu_cdb_data,
    input  logic                  lsb_cdb_valid,
    input  logic [ROB_ADDR_W-1:0] lsb_cdb_robnum,
    input  logic [31:0]           lsb_cdb_data,
    output logic                  full,
    output logic                  has_to_alu,
    output logic [31:0]           imm,
    output logic [OP_W-1:0]       op,
    output logic [31:0]           pc,
    output logic [4:0]            shamt,
    output logic [ROB_ADDR_W-1:0] rd_robnum,
    output logic [31:0]           rs1_oprand,
    output logic [31:0]           rs2_oprand
);
    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]    busy_q, busy_d;
    logic [RS_SIZE-1:0]    rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;
    logic [OP_W-1:0]       ent_op_q    [RS_SIZE], ent_op_d    [RS_SIZE];
    logic [31:0]           ent_imm_q   [RS_SIZE], ent_imm_d   [RS_SIZE];
    logic [31:0]           ent_pc_q    [RS_SIZE], ent_pc_d    [RS_SIZE];
    logic [4:0]            ent_shamt_q [RS_SIZE], ent_shamt_d [RS_SIZE];
    logic [ROB_ADDR_W-1:0] ent_rob_q   [RS_SIZE], ent_rob_d   [RS_SIZE];
    logic [31:0]           rs1_val_q   [RS_SIZE], rs1_val_d   [RS_SIZE];
    logic [31:0]           rs2_val_q   [RS_SIZE], rs2_val_d   [RS_SIZE];
    logic [ROB_ADDR_W-1:0] rs1_tag_q   [RS_SIZE], rs1_tag_d   [RS_SIZE];
    logic [ROB_ADDR_W-1:0] rs2_tag_q   [RS_SIZE], rs2_tag_d   [RS_SIZE];

    logic                  has_to_alu_q, has_to_alu_d;
    logic [31:0]           out_imm_q, out_imm_d, out_pc_q, out_pc_d;
    logic [OP_W-1:0]       out_op_q, out_op_d;
    logic [4:0]            out_shamt_q, out_shamt_d;
    logic [ROB_ADDR_W-1:0] out_rob_q, out_rob_d;
    logic [31:0]           out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;

    logic [32:0]           wk1 [RS_SIZE];
    logic [32:0]           wk2 [RS_SIZE];
    logic [32:0]           in_wk1, in_wk2;
    logic [RS_SIZE-1:0]    cand;
    logic                  sel_found;
    logic [IDX_W-1:0]      sel_idx, free_idx;

    // Returns {ready, value} after snooping both buses; ALU bus wins on a double match.
    function automatic logic [32:0] wake(input logic r, input logic [31:0] v,
                                         input logic [ROB_ADDR_W-1:0] t);
        if (r)                                   return {1'b1, v};
        if (alu_cdb_valid && alu_cdb_robnum == t) return {1'b1, alu_cdb_data};
        if (lsb_cdb_valid && lsb_cdb_robnum == t) return {1'b1, lsb_cdb_data};
        return {1'b0, v};
    endfunction

    assign full = &busy_q;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            wk1[i] = wake(rs1_rdy_q[i], rs1_val_q[i], rs1_tag_q[i]);
            wk2[i] = wake(rs2_rdy_q[i], rs2_val_q[i], rs2_tag_q[i]);
`ifdef ALU_RS_BYPASS_EN
            cand[i] = busy_q[i] && wk1[i][32] && wk2[i][32];
`else
            cand[i] = busy_q[i] && rs1_rdy_q[i] && rs2_rdy_q[i];
`endif
        end
        in_wk1 = wake(in_rs1_ready, in_rs1_val, in_rs1_tag);
        in_wk2 = wake(in_rs2_ready, in_rs2_val, in_rs2_tag);
    end

    // Descending scans leave the lowest matching index in place.
    always_comb begin
        sel_found = |cand;
        sel_idx   = '0;
        free_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (cand[i])    sel_idx  = IDX_W'(i);
            if (!busy_q[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        busy_d      = busy_q;
        rs1_rdy_d   = rs1_rdy_q;
        rs2_rdy_d   = rs2_rdy_q;
        ent_op_d    = ent_op_q;
        ent_imm_d   = ent_imm_q;
        ent_pc_d    = ent_pc_q;
        ent_shamt_d = ent_shamt_q;
        ent_rob_d   = ent_rob_q;
        rs1_val_d   = rs1_val_q;
        rs2_val_d   = rs2_val_q;
        rs1_tag_d   = rs1_tag_q;
        rs2_tag_d   = rs2_tag_q;
        has_to_alu_d = 1'b0;
        out_imm_d   = out_imm_q;
        out_pc_d    = out_pc_q;
        out_op_d    = out_op_q;
        out_shamt_d = out_shamt_q;
        out_rob_d   = out_rob_q;
        out_rs1_d   = out_rs1_q;
        out_rs2_d   = out_rs2_q;

        if (has_misbranch) begin
            busy_d = '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i]) begin
                    rs1_rdy_d[i] = wk1[i][32];
                    rs1_val_d[i] = wk1[i][31:0];
                    rs2_rdy_d[i] = wk2[i][32];
                    rs2_val_d[i] = wk2[i][31:0];
                end
            end
            // Operands come from the snooped view so a bypassed wakeup issues CDB data.
            if (sel_found) begin
                busy_d[sel_idx] = 1'b0;
                has_to_alu_d    = 1'b1;
                out_op_d        = ent_op_q[sel_idx];
                out_imm_d       = ent_imm_q[sel_idx];
                out_pc_d        = ent_pc_q[sel_idx];
                out_shamt_d     = ent_shamt_q[sel_idx];
                out_rob_d       = ent_rob_q[sel_idx];
                out_rs1_d       = wk1[sel_idx][31:0];
                out_rs2_d       = wk2[sel_idx][31:0];
            end
            if (in_valid && !full) begin
                busy_d[free_idx]      = 1'b1;
                ent_op_d[free_idx]    = in_op;
                ent_imm_d[free_idx]   = in_imm;
                ent_pc_d[free_idx]    = in_pc;
                ent_shamt_d[free_idx] = in_shamt;
                ent_rob_d[free_idx]   = in_rd_robnum;
                rs1_rdy_d[free_idx]   = in_wk1[32];
                rs1_val_d[free_idx]   = in_wk1[31:0];
                rs1_tag_d[free_idx]   = in_rs1_tag;
                rs2_rdy_d[free_idx]   = in_wk2[32];
                rs2_val_d[free_idx]   = in_wk2[31:0];
                rs2_tag_d[free_idx]   = in_rs2_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q       <= '0;
            has_to_alu_q <= 1'b0;
            out_imm_q    <= '0;
            out_pc_q     <= '0;
            out_op_q     <= '0;
            out_shamt_q  <= '0;
            out_rob_q    <= '0;
            out_rs1_q    <= '0;
            out_rs2_q    <= '0;
        end else if (rdy) begin
            busy_q       <= busy_d;
            has_to_alu_q <= has_to_alu_d;
            out_imm_q    <= out_imm_d;
            out_pc_q     <= out_pc_d;
            out_op_q     <= out_op_d;
            out_shamt_q  <= out_shamt_d;
            out_rob_q    <= out_rob_d;
            out_rs1_q    <= out_rs1_d;
            out_rs2_q    <= out_rs2_d;
        end
    end

    // Entry payload is only meaningful while busy, so it carries no reset.
    always_ff @(posedge clk) begin
        if (rdy) begin
            rs1_rdy_q   <= rs1_rdy_d;
            rs2_rdy_q   <= rs2_rdy_d;
            ent_op_q    <= ent_op_d;
            ent_imm_q   <= ent_imm_d;
            ent_pc_q    <= ent_pc_d;
            ent_shamt_q <= ent_shamt_d;
            ent_rob_q   <= ent_rob_d;
            rs1_val_q   <= rs1_val_d;
            rs2_val_q   <= rs2_val_d;
            rs1_tag_q   <= rs1_tag_d;
            rs2_tag_q   <= rs2_tag_d;
        end
    end

    assign has_to_alu = has_to_alu_q;
    assign imm        = out_imm_q;
    assign op         = out_op_q;
    assign pc         = out_pc_q;
    assign shamt      = out_shamt_q;
    assign rd_robnum  = out_rob_q;
    assign rs1_oprand = out_rs1_q;
    assign rs2_oprand = out_rs2_q;
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs; follows the bypass latency when ALU_RS_BYPASS_EN is defined.
module tb_alu_rs;
    logic        clk = 1'b0;
    logic        rst_n, rdy, has_misbranch, in_valid;
    logic [5:0]  in_op;
    logic [31:0] in_imm, in_pc, in_rs1_val, in_rs2_val;
    logic [4:0]  in_shamt;
    logic [3:0]  in_rd_robnum, in_rs1_tag, in_rs2_tag;
    logic        in_rs1_ready, in_rs2_ready;
    logic        alu_cdb_valid, lsb_cdb_valid;
    logic [3:0]  alu_cdb_robnum, lsb_cdb_robnum;
    logic [31:0] alu_cdb_data, lsb_cdb_data;
    logic        full, has_to_alu;
    logic [31:0] imm, pc, rs1_oprand, rs2_oprand;
    logic [5:0]  op;
    logic [4:0]  shamt;
    logic [3:0]  rd_robnum;
    int total = 0;
    int bad   = 0;

    alu_rs #(.RS_SIZE(16), .ROB_ADDR_W(4), .OP_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .has_misbranch(has_misbranch),
        .in_valid(in_valid), .in_op(in_op), .in_imm(in_imm), .in_pc(in_pc),
        .in_shamt(in_shamt), .in_rd_robnum(in_rd_robnum),
        .in_rs1_ready(in_rs1_ready), .in_rs2_ready(in_rs2_ready),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_rs1_tag(in_rs1_tag), .in_rs2_tag(in_rs2_tag),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_robnum(alu_cdb_robnum), .alu_cdb_data(alu_cdb_data),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_robnum(lsb_cdb_robnum), .lsb_cdb_data(lsb_cdb_data),
        .full(full), .has_to_alu(has_to_alu), .imm(imm), .op(op), .pc(pc), .shamt(shamt),
        .rd_robnum(rd_robnum), .rs1_oprand(rs1_oprand), .rs2_oprand(rs2_oprand)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0; has_misbranch = 1'b0;
        alu_cdb_valid = 1'b0; alu_cdb_robnum = '0; alu_cdb_data = '0;
        lsb_cdb_valid = 1'b0; lsb_cdb_robnum = '0; lsb_cdb_data = '0;
    endtask

    // op/imm/pc/shamt are derived from the ROB tag so issued fields are predictable.
    task automatic disp(input logic [3:0] rob, input logic r1r, input logic [31:0] r1v,
                        input logic [3:0] r1t, input logic r2r, input logic [31:0] r2v,
                        input logic [3:0] r2t);
        in_valid = 1'b1; in_rd_robnum = rob;
        in_op = {2'b10, rob}; in_imm = {28'h1234560, rob};
        in_pc = 32'h1000 + {26'd0, rob, 2'b00}; in_shamt = {1'b0, rob} + 5'd1;
        in_rs1_ready = r1r; in_rs1_val = r1v; in_rs1_tag = r1t;
        in_rs2_ready = r2r; in_rs2_val = r2v; in_rs2_tag = r2t;
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; idle();
        disp(4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0); in_valid = 1'b0;
        step(); step();
        check("reset_has_to_alu", has_to_alu, 0);
        check("reset_full", full, 0);
        check("reset_rd_robnum", rd_robnum, 0);
        check("reset_rs1", rs1_oprand, 0);
        rst_n = 1'b1;

        // Both operands ready: issues one edge after the dispatch edge.
        disp(4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
        step(); idle();
        check("add_not_same_edge", has_to_alu, 0);
        step();
        check("add_issue", has_to_alu, 1);
        check("add_rs1", rs1_oprand, 32'd5);
        check("add_rs2", rs2_oprand, 32'd7);
        check("add_rob", rd_robnum, 32'd3);
        check("add_op", op, 32'h23);
        check("add_imm", imm, 32'h12345603);
        check("add_pc", pc, 32'h100C);
        check("add_shamt", shamt, 32'd4);
        step();
        check("add_one_shot", has_to_alu, 0);
        check("add_hold_rs1", rs1_oprand, 32'd5);

        // ALU CDB wakeup of rs1.
        disp(4'd5, 1'b0, 32'd0, 4'd2, 1'b1, 32'h22, 4'd0);
        step(); idle();
        step();
        check("wake_wait", has_to_alu, 0);
        alu_cdb_valid = 1'b1; alu_cdb_robnum = 4'd2; alu_cdb_data = 32'h10;
        step(); idle();
`ifndef ALU_RS_BYPASS_EN
        check("wake_not_early", has_to_alu, 0);
        step();
`endif
        check("wake_issue", has_to_alu, 1);
        check("wake_rs1", rs1_oprand, 32'h10);
        check("wake_rs2", rs2_oprand, 32'h22);
        check("wake_rob", rd_robnum, 32'd5);

        // LSB CDB captured during dispatch.
        disp(4'd7, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd6);
        lsb_cdb_valid = 1'b1; lsb_cdb_robnum = 4'd6; lsb_cdb_data = 32'hABCD;
        step(); idle();
        step();
        check("disp_cap_issue", has_to_alu, 1);
        check("disp_cap_rs2", rs2_oprand, 32'hABCD);
        check("disp_cap_rob", rd_robnum, 32'd7);

        // Fill all 16 entries with rs1 waiting on tag i.
        for (int i = 0; i < 16; i++) begin
            disp(4'(i), 1'b0, 32'd0, 4'(i), 1'b1, 32'(i), 4'd0);
            step();
            check($sformatf("fill_full_%0d", i), full, (i == 15) ? 32'd1 : 32'd0);
        end
        disp(4'd15, 1'b1, 32'h77, 4'd0, 1'b1, 32'h88, 4'd0);
        step(); idle();
        check("overflow_full", full, 1);
        step();
        check("overflow_no_issue", has_to_alu, 0);

        alu_cdb_valid = 1'b1; alu_cdb_robnum = 4'd9; alu_cdb_data = 32'h99;
        lsb_cdb_valid = 1'b1; lsb_cdb_robnum = 4'd4; lsb_cdb_data = 32'h44;
        step(); idle();
`ifndef ALU_RS_BYPASS_EN
        check("pair_not_early", has_to_alu, 0);
        step();
`endif
        check("pair_first_issue", has_to_alu, 1);
        check("pair_first_rob", rd_robnum, 32'd4);
        check("pair_first_rs1", rs1_oprand, 32'h44);
        check("pair_first_rs2", rs2_oprand, 32'd4);
        check("pair_freed", full, 0);
        step();
        check("pair_second_issue", has_to_alu, 1);
        check("pair_second_rob", rd_robnum, 32'd9);
        check("pair_second_rs1", rs1_oprand, 32'h99);

        // Flush with a simultaneous wakeup and dispatch; neither survives.
        has_misbranch = 1'b1;
        alu_cdb_valid = 1'b1; alu_cdb_robnum = 4'd2; alu_cdb_data = 32'h2;
        disp(4'd13, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
        step(); idle();
        check("flush_no_issue", has_to_alu, 0);
        check("flush_empty", full, 0);
        check("flush_hold_rob", rd_robnum, 32'd9);
        step();
        check("flush_disp_dropped", has_to_alu, 0);
        alu_cdb_valid = 1'b1; alu_cdb_robnum = 4'd3; alu_cdb_data = 32'h3;
        step(); idle();
        check("flush_late_wake_a", has_to_alu, 0);
        step();
        check("flush_late_wake_b", has_to_alu, 0);

        // A registered-ready candidate is not issued on the flush edge.
        disp(4'd10, 1'b1, 32'hA1, 4'd0, 1'b1, 32'hA2, 4'd0);
        step(); idle();
        has_misbranch = 1'b1;
        step(); idle();
        check("flush_kills_cand", has_to_alu, 0);
        step();
        check("flush_kills_cand_b", has_to_alu, 0);

        // rdy low freezes a pending issue and the outputs.
        disp(4'd11, 1'b1, 32'h31, 4'd0, 1'b1, 32'h32, 4'd0);
        step();
        disp(4'd12, 1'b1, 32'h41, 4'd0, 1'b1, 32'h42, 4'd0);
        step(); idle();
        check("stall_pre_issue", has_to_alu, 1);
        check("stall_pre_rob", rd_robnum, 32'd11);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_hold_v_%0d", i), has_to_alu, 1);
            check($sformatf("stall_hold_rob_%0d", i), rd_robnum, 32'd11);
            check($sformatf("stall_hold_rs1_%0d", i), rs1_oprand, 32'h31);
        end
        rdy = 1'b1;
        step();
        check("stall_resume_issue", has_to_alu, 1);
        check("stall_resume_rob", rd_robnum, 32'd12);
        check("stall_resume_rs1", rs1_oprand, 32'h41);
        step();
        check("stall_drain", has_to_alu, 0);

        // Reset while stalled discards pending entries.
        disp(4'd14, 1'b0, 32'd0, 4'd5, 1'b1, 32'h5, 4'd0);
        step(); idle();
        rst_n = 1'b0; rdy = 1'b0;
        step();
        check("midrst_rob", rd_robnum, 0);
        check("midrst_rs1", rs1_oprand, 0);
        check("midrst_full", full, 0);
        rst_n = 1'b1; rdy = 1'b1;
        alu_cdb_valid = 1'b1; alu_cdb_robnum = 4'd5; alu_cdb_data = 32'h55;
        step(); idle();
        check("midrst_wake_a", has_to_alu, 0);
        step();
        check("midrst_wake_b", has_to_alu, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station feeding the integer ALU.
- Buffers dispatched ALU/branch/jump µops until both source operands are available.
- Captures operand values from the two result broadcast buses (ALU and load/store buffer).
- Issues at most one ready µop per cycle to the ALU, through registered outputs.

Parameters:
- RS_SIZE, 16, number of entries (power of two, ≥2)
- ROB_ADDR_W, 4, width of ROB tag
- OP_W, 6, width of internal opcode encoding

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rdy  in  1  global ready; when 0, all state and outputs hold
- has_misbranch  in  1  flush request
- in_valid  in  1  dispatch strobe
- in_op  in  OP_W  opcode
- in_imm  in  32  immediate
- in_pc  in  32  instruction pc
- in_shamt  in  5  shift amount
- in_rd_robnum  in  ROB_ADDR_W  destination ROB tag
- in_rs1_ready / in_rs2_ready  in  1  operand already valid
- in_rs1_val / in_rs2_val  in  32  operand value when ready
- in_rs1_tag / in_rs2_tag  in  ROB_ADDR_W  producing ROB tag when not ready
- alu_cdb_valid  in  1  ALU result broadcast
- alu_cdb_robnum  in  ROB_ADDR_W  tag
- alu_cdb_data  in  32  value
- lsb_cdb_valid  in  1  load result broadcast
- lsb_cdb_robnum  in  ROB_ADDR_W  tag
- lsb_cdb_data  in  32  value
- full  out  1  no free entry (combinational from current busy bits)
- has_to_alu  out  1  issue strobe
- imm, op, pc, shamt, rd_robnum, rs1_oprand, rs2_oprand  out  as ALU inputs  issued µop fields

Behaviour:
- Reset: rst_n=0 at clk edge → all busy bits 0; has_to_alu=0; other outputs 0. Reset mid-operation discards all entries; rst_n dominates rdy.
- rdy=0: no dispatch, wakeup, issue or flush takes effect; registers hold.
- Entry fields: busy, op, imm, pc, shamt, robnum, and per operand {rdy, val, tag}.
- Dispatch (in_valid && !full): write the lowest-index free entry, busy=1.
  - Operand not ready whose tag matches a valid CDB in the same cycle → stored ready with the CDB value.
  - ALU CDB has priority over LSB CDB if both match (cannot occur legally).
  - in_valid while full: ignored; no state change.
- Wakeup: each cycle, every busy entry with operand rdy=0 and tag equal to a valid CDB robnum captures the data and sets rdy=1. Both operands may wake in the same cycle.
- Select/issue:
  - Among busy entries with both rdy=1 in the current registered state, pick the lowest index.
  - Next edge: has_to_alu=1, outputs loaded from that entry, entry busy cleared.
  - No candidate → has_to_alu=0; other outputs hold.
  - Latency: a µop dispatched with both operands ready issues one edge later at earliest, so has_to_alu is high in cycle N+1 for dispatch in cycle N.
  - An entry written this cycle is never a candidate this cycle.
- Same-cycle dispatch and issue: both take effect. The freed slot is not reusable until the next cycle, because full is computed from pre-edge busy bits.
- Flush (has_misbranch=1, rdy=1): all busy cleared and has_to_alu=0 next edge. Dispatch and issue that cycle are suppressed.
- Wrap/boundary: the occupancy count is implicit in busy bits; full=1 only when all RS_SIZE are busy.

Optional Feature:
ALU_RS_BYPASS_EN
- Defined: an entry whose last missing operand(s) match a valid CDB this cycle is also a select candidate this cycle, and the issued operand is taken directly from the CDB data. Wake-to-issue becomes 1 edge.
- Undefined: the woken entry is first eligible next cycle. Wake-to-issue is 2 edges.

Test Plan:
- Reset then dispatch add (rs1 ready=5, rs2 ready=7, robnum 3) → next cycle has_to_alu=1, rs1_oprand=5, rs2_oprand=7, rd_robnum=3; following cycle has_to_alu=0.
- Dispatch with rs1 tag=2 not ready; cycle later alu_cdb_valid, robnum 2, data 0x10 → has_to_alu=1, rs1_oprand=0x10 two edges after CDB (bypass off) / one edge after (bypass on).
- Dispatch with rs2 tag=6 while lsb_cdb broadcasts robnum 6 data 0xABCD the same cycle → captured; issue next edge with rs2_oprand=0xABCD.
- Fill 16 dependent entries → full=1; 17th in_valid ignored. Wake entries 9 and 4 together → entry 4 issues first, then 9.
- Fill 5 entries, assert has_misbranch with rdy=1 → next cycle full=0, has_to_alu=0; an entry woken later never issues.
- rdy=0 for 3 cycles with a ready entry pending → no issue and outputs hold; issue occurs on the first edge with rdy=1.
